// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Low address bits must equal this for a word-aligned access.
  localparam logic [1:0] ALIGN_OK = 2'b00;

  typedef struct packed {
    logic valid;
    logic err;
  } rsp_ctrl_t;

  localparam rsp_ctrl_t RSP_ZERO = '{valid: 1'b0, err: 1'b0};

endpackage

// File: rtl/mem_word_ram.sv
// Word-addressed storage with synchronous write and registered synchronous read.
module mem_word_ram #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int IdxWidth  = 10
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [IdxWidth-1:0]  addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[addr] <= wdata;
    end
    if (ren) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-port memory target: one request at a time, fixed wait states, single-cycle response.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 1024,
  parameter int WaitStates = 2
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

  state_t                state;
  logic [CntWidth-1:0]   cnt;
  rsp_ctrl_t             rsp;
  logic                  rd_sel;

  logic                  we_q;
  logic                  err_q;
  logic [IdxWidth-1:0]   idx_q;
  logic [DataWidth-1:0]  wdata_q;

  logic [AddrWidth-1:0]  word_idx;
  logic                  req_bad;
  logic                  accept;
  logic                  do_access;
  logic                  ram_wen;
  logic                  ram_ren;
  logic [DataWidth-1:0]  ram_rdata;

  // Upper address bits are deliberately not masked: anything past Depth is an error.
  assign word_idx  = AddrWidth'(req_addr[AddrWidth-1:2]);
  assign req_bad   = (req_addr[1:0] != ALIGN_OK) || (word_idx >= AddrWidth'(Depth));

  assign req_ready = (state == IDLE) && RESET;
  assign accept    = req_valid && req_ready;
  assign do_access = (state == ACCESS) && (cnt == '0);

  // Gating with RESET keeps a reset on the access edge from touching memory.
  assign ram_wen   = do_access && !err_q && we_q && RESET;
  assign ram_ren   = do_access && !err_q && !we_q && RESET;

  assign rsp_valid = rsp.valid;
  assign rsp_err   = rsp.err;
  assign rsp_rdata = rd_sel ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      rsp    <= RSP_ZERO;
      rd_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CntWidth'(WaitStates);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp.valid <= 1'b1;
            rsp.err   <= err_q;
            rd_sel    <= !err_q && !we_q;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp.valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request payload: captured on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      err_q   <= req_bad;
      idx_q   <= req_addr[IdxWidth+1:2];
      wdata_q <= req_wdata;
    end
  end

  mem_word_ram #(
    .DataWidth(DataWidth),
    .Depth    (Depth),
    .IdxWidth (IdxWidth)
  ) u_ram (
    .clk  (clk),
    .wen  (ram_wen),
    .ren  (ram_ren),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at default parameters (WaitStates=2, Depth=1024).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk      (clk),
    .RESET    (RESET),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  // Drives one request, then watches 8 cycles for response pulses.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic ok, output int lat, output int npulse,
                      output logic [31:0] rdata, output logic err);
    ok = 1'b0; lat = -1; npulse = 0; rdata = 'x; err = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (npulse == 0) begin
          lat = n; rdata = rsp_rdata; err = rsp_err;
        end
        npulse++;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    RESET = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: ready=%b valid=%b err=%b rdata=%h, want 0 0 0 0",
                 i, req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_accept_next_edge: ready=%b want 0 (busy)", req_ready);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_first_rsp: pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_write_read();
    logic ok, err; int lat, np; logic [31:0] rd;
    xact(1'b1, 32'h10, 32'hDEADBEEF, ok, lat, np, rd, err);
    checks++;
    if (!ok || lat != 4 || np != 1 || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL write_10: ok=%b lat=%0d pulses=%0d err=%b rdata=%h want 1 4 1 0 00000000",
               ok, lat, np, err, rd);
    end
    xact(1'b0, 32'h10, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || lat != 4 || np != 1 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_10: ok=%b lat=%0d pulses=%0d err=%b rdata=%h want 1 4 1 0 deadbeef",
               ok, lat, np, err, rd);
    end
  endtask

  task automatic test_misaligned();
    logic ok, err; int lat, np; logic [31:0] rd;
    xact(1'b1, 32'h12, 32'h00000001, ok, lat, np, rd, err);
    checks++;
    if (!ok || np != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_write: ok=%b pulses=%0d err=%b rdata=%h want 1 1 1 00000000",
               ok, np, err, rd);
    end
    xact(1'b0, 32'h10, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misaligned_no_write: err=%b rdata=%h want 0 deadbeef", err, rd);
    end
  endtask

  task automatic test_out_of_range();
    logic ok, err; int lat, np; logic [31:0] rd;
    xact(1'b1, 32'h1000, 32'h77777777, ok, lat, np, rd, err);
    checks++;
    if (!ok || np != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_write_1000: err=%b rdata=%h want 1 00000000", err, rd);
    end
    xact(1'b0, 32'h1000, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || np != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_read_1000: err=%b rdata=%h want 1 00000000", err, rd);
    end
    xact(1'b1, 32'hFFC, 32'hA5A5C3C3, ok, lat, np, rd, err);
    xact(1'b0, 32'hFFC, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || np != 1 || err !== 1'b0 || rd !== 32'hA5A5C3C3) begin
      errors++;
      $display("FAIL last_word_ffc: err=%b rdata=%h want 0 a5a5c3c3", err, rd);
    end
    // Index 0 aliases only if upper bits were masked; 0x40000000 must error.
    xact(1'b0, 32'h4000_0000, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL high_bits_unmasked: err=%b rdata=%h want 1 00000000", err, rd);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t[3];
    int nacc = 0, pulses = 0, busy = 0, bad_data = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) bad_data++;
      end
      if (req_valid) begin
        if (req_ready === 1'b1) begin
          acc_t[nacc] = i;
          nacc++;
          if (nacc == 3) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
          end
        end else begin
          busy++;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nacc != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 3", nacc);
    end else begin
      checks++;
      if (acc_t[1] - acc_t[0] != 5 || acc_t[2] - acc_t[1] != 5) begin
        errors++;
        $display("FAIL b2b_spacing: gaps %0d %0d want 5 5", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
      end
    end
    checks++;
    if (busy != 8) begin
      errors++;
      $display("FAIL b2b_ready_low: busy cycles %0d want 8", busy);
    end
    checks++;
    if (pulses != 3 || bad_data != 0) begin
      errors++;
      $display("FAIL b2b_pulses: pulses=%0d bad=%0d want 3 0", pulses, bad_data);
    end
  endtask

  task automatic test_reset_mid_op();
    logic ok, err; int lat, np, pulses; logic [31:0] rd;
    xact(1'b1, 32'h20, 32'h11111111, ok, lat, np, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h00000055;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_ready: got %b want 1", req_ready);
    end
    @(posedge clk);         // accept, cnt=2
    #1 req_valid = 1'b0;
    @(posedge clk);         // cnt=1
    #1 RESET = 1'b0;
    @(posedge clk);
    #1 RESET = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midop_no_rsp: pulses=%0d want 0", pulses);
    end
    xact(1'b0, 32'h20, 32'h0, ok, lat, np, rd, err);
    checks++;
    if (!ok || err !== 1'b0 || rd !== 32'h11111111) begin
      errors++;
      $display("FAIL midop_mem_kept: err=%b rdata=%h want 0 11111111", err, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
